// File: rtl/parametric_cellular_automata_runner_pkg.sv
// Shared definitions for the cellular automaton runner: boundary modes,
// FSM encodings and the rule-table size helper.
package parametric_cellular_automata_runner_pkg;

  localparam int unsigned BOUND_W = 2;

  localparam logic [BOUND_W-1:0] CA_BOUND_WRAP = 2'd0;
  localparam logic [BOUND_W-1:0] CA_BOUND_ZERO = 2'd1;
  localparam logic [BOUND_W-1:0] CA_BOUND_ONE  = 2'd2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Rule table size for a neighbourhood of 2*radius+1 cells.
  function automatic int unsigned rule_bits(input int unsigned radius);
    return 32'd1 << (2 * radius + 1);
  endfunction

endpackage

// File: rtl/parametric_cellular_automata_runner_if.sv
// Host-side control/status bundle of the cellular automaton runner.
// master: host (drives ce, rule, boundary, set, load, start, steps)
// slave : runner (drives state, generation, busy, done, stable)
interface parametric_cellular_automata_runner_if
  import parametric_cellular_automata_runner_pkg::*;
#(
  parameter int unsigned Width      = 16,
  parameter int unsigned Radius     = 1,
  parameter int unsigned CountWidth = 16
);
  localparam int unsigned RuleBits = rule_bits(Radius);

  logic                  ce;
  logic [RuleBits-1:0]   rule;
  logic [BOUND_W-1:0]    boundary;
  logic [Width-1:0]      set;
  logic                  load;
  logic                  start;
  logic [CountWidth-1:0] steps;
  logic [Width-1:0]      state;
  logic [CountWidth-1:0] generation;
  logic                  busy;
  logic                  done;
  logic                  stable;

  modport master (
    output ce, rule, boundary, set, load, start, steps,
    input  state, generation, busy, done, stable
  );

  modport slave (
    input  ce, rule, boundary, set, load, start, steps,
    output state, generation, busy, done, stable
  );
endinterface

// File: rtl/parametric_cellular_automata_runner_ca_next_state.sv
// Combinational one-generation update of the whole lattice.
// state_i    : current lattice, bit Width-1 is the leftmost cell
// rule_i     : transition table indexed by {c[i+R] .. c[i-R]}
// boundary_i : wrap / zeros / ones (reserved behaves as zeros)
// next_o     : lattice after one generation
module ca_next_state
  import parametric_cellular_automata_runner_pkg::*;
#(
  parameter int unsigned Width  = 16,
  parameter int unsigned Radius = 1
) (
  input  logic [Width-1:0]             state_i,
  input  logic [rule_bits(Radius)-1:0] rule_i,
  input  logic [BOUND_W-1:0]           boundary_i,
  output logic [Width-1:0]             next_o
);
  localparam int unsigned NbW = 2 * Radius + 1;

  logic wrap;
  logic fill;

  assign wrap = (boundary_i == CA_BOUND_WRAP);
  assign fill = (boundary_i == CA_BOUND_ONE);

  // Tap positions are elaboration constants, so edge cells pick their
  // wrapped neighbour or the fill value without any run-time indexing.
  for (genvar gi = 0; gi < Width; gi++) begin : g_cell
    logic [NbW-1:0] idx;
    for (genvar gk = 0; gk < NbW; gk++) begin : g_tap
      localparam int J = int'(gi) + int'(Radius) - int'(gk);
      if (J >= 0 && J < int'(Width)) begin : g_in
        assign idx[NbW-1-gk] = state_i[J];
      end else begin : g_edge
        assign idx[NbW-1-gk] = wrap ? state_i[(J + int'(Width)) % int'(Width)] : fill;
      end
    end
    assign next_o[gi] = rule_i[idx];
  end

endmodule

// File: rtl/parametric_cellular_automata_runner.sv
// Runs a programmed number of generations of a 1-D binary cellular
// automaton under a start/busy/done handshake, with optional fixed-point stop.
// clk : rising-edge clock
// rst : asynchronous reset, active-low
// bus : slave side of the host bundle (config in, lattice/status out)
module parametric_cellular_automata_runner
  import parametric_cellular_automata_runner_pkg::*;
#(
  parameter int unsigned Width       = 16,
  parameter int unsigned Radius      = 1,
  parameter int unsigned CountWidth  = 16,
  parameter int unsigned StopOnFixed = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  parametric_cellular_automata_runner_if.slave  bus
);
  localparam int unsigned RuleBits = rule_bits(Radius);

  logic [0:0]            fsm_q, fsm_d;
  logic [Width-1:0]      state_q, state_d;
  logic [CountWidth-1:0] gen_q, gen_d;
  logic [CountWidth-1:0] steps_q, steps_d;
  logic [RuleBits-1:0]   rule_q, rule_d;
  logic [BOUND_W-1:0]    bound_q, bound_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  stable_q, stable_d;

  logic [Width-1:0]      next_state;
  logic [CountWidth-1:0] gen_inc;
  logic                  fixed;

  ca_next_state #(
    .Width  (Width),
    .Radius (Radius)
  ) u_next (
    .state_i    (state_q),
    .rule_i     (rule_q),
    .boundary_i (bound_q),
    .next_o     (next_state)
  );

  assign gen_inc = gen_q + CountWidth'(1);
  assign fixed   = (next_state == state_q);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      gen_q    <= '0;
      steps_q  <= '0;
      rule_q   <= '0;
      bound_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      gen_q    <= gen_d;
      steps_q  <= steps_d;
      rule_q   <= rule_d;
      bound_q  <= bound_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      stable_q <= stable_d;
    end
  end

  // Next-state and output decode; everything holds while ce is low.
  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    gen_d    = gen_q;
    steps_d  = steps_q;
    rule_d   = rule_q;
    bound_d  = bound_q;
    busy_d   = busy_q;
    done_d   = done_q;
    stable_d = stable_q;
    if (bus.ce) begin
      done_d = 1'b0;
      case (fsm_q)
        IDLE: begin
          if (bus.load) begin
            state_d  = bus.set;
            stable_d = 1'b0;
          end else if (bus.start) begin
            gen_d = '0;
            if (bus.steps == '0) begin
              done_d = 1'b1;
            end else begin
              rule_d  = bus.rule;
              bound_d = bus.boundary;
              steps_d = bus.steps;
              busy_d  = 1'b1;
              fsm_d   = RUN;
            end
          end
        end
        RUN: begin
          state_d  = next_state;
          gen_d    = gen_inc;
          stable_d = fixed;
          if ((gen_inc == steps_q) || ((StopOnFixed != 0) && fixed)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            fsm_d  = IDLE;
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  assign bus.state      = state_q;
  assign bus.generation = gen_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.stable     = stable_q;

endmodule
